// File: rtl/mlp_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mlp_dispatch_pkg
// Purpose  : Shared types and constants for the mlp_1 dispatch splitter and
//            the benches that drive it.
// Contents : state_e        - splitter FSM encoding (IDLE, BUSY)
//            idx_width()    - index width helper, never narrower than 1 bit
//            MLP_*          - default geometry of the mlp_1 dispatch path
// Revision : 1.0 - initial release
// ============================================================================
package mlp_dispatch_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int MLP_DATA_WIDTH  = 64;
  localparam int MLP_CHUNK_WORDS = 8;
  localparam int MLP_NUM_LANES   = 4;

  // A 1-entry space still needs a 1-bit index so the counters stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MLP_LANE_IDX_W = idx_width(MLP_NUM_LANES);

endpackage
`default_nettype wire

// File: rtl/axis_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : axis_skid_buffer
// Purpose  : 2-entry stream buffer with a registered ready. Sustains one
//            transfer per cycle while the sink keeps up, and absorbs one extra
//            word when the sink stalls so ready never depends combinationally
//            on the sink.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            s_data_i/s_valid_i    - upstream word and valid
//            s_ready_o             - registered "not full"
//            m_data_o/m_valid_o    - head word and valid
//            m_ready_i             - sink takes the head word this edge
//            second_valid_o        - both entries occupied
// Revision : 1.0 - initial release
// ============================================================================
module axis_skid_buffer #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             second_valid_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             ready_q;
  logic             w_push;
  logic             w_pop;

  assign w_push = s_valid_i & ready_q;
  assign w_pop  = m_ready_i & (count_q != 2'd0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = s_data_i;
        else                 tail_d = s_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the incoming word lands behind whatever
        // is left after the pop.
        if (count_q == 2'd2) begin
          head_d = tail_q;
          tail_d = s_data_i;
        end else begin
          head_d = s_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // Ready is derived from next occupancy so a full buffer never sees
      // another push.
      ready_q <= (count_d != 2'd2);
    end
  end

  assign s_ready_o      = ready_q;
  assign m_data_o       = head_q;
  assign m_valid_o      = (count_q != 2'd0);
  assign second_valid_o = (count_q == 2'd2);

endmodule
`default_nettype wire

// File: rtl/mlp_dispatch_splitter.sv
`default_nettype none
// ============================================================================
// Module   : mlp_dispatch_splitter
// Purpose  : Splits one AXI-Stream of input-vector words into CHUNK_WORDS
//            chunks sent round-robin to the dispatcher input FIFOs. Every
//            vector restarts at lane 0, chunk word 0.
// Ports    : clk, reset                     - clock, sync active-high reset
//            s_axis_tdata/tvalid/tlast/tready - input stream
//            dispatcherN_ififo_wdata/wen    - lane N write port (N = 0..3)
//            dispatcherN_ififo_rdy          - lane N has room for one write
//            vec_count                      - vectors dispatched (wraps)
//            frame_err                      - sticky short-chunk flag
//            busy                           - vector or write in flight
// Revision : 1.0 - initial release
// ============================================================================
module mlp_dispatch_splitter
  import mlp_dispatch_pkg::*;
#(
  parameter int DATA_WIDTH  = MLP_DATA_WIDTH,
  parameter int NUM_LANES   = MLP_NUM_LANES,
  parameter int CHUNK_WORDS = MLP_CHUNK_WORDS,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] dispatcher0_ififo_wdata,
  output logic                  dispatcher0_ififo_wen,
  input  logic                  dispatcher0_ififo_rdy,
  output logic [DATA_WIDTH-1:0] dispatcher1_ififo_wdata,
  output logic                  dispatcher1_ififo_wen,
  input  logic                  dispatcher1_ififo_rdy,
  output logic [DATA_WIDTH-1:0] dispatcher2_ififo_wdata,
  output logic                  dispatcher2_ififo_wen,
  input  logic                  dispatcher2_ififo_rdy,
  output logic [DATA_WIDTH-1:0] dispatcher3_ififo_wdata,
  output logic                  dispatcher3_ififo_wen,
  input  logic                  dispatcher3_ififo_rdy,
  output logic [CNT_WIDTH-1:0]  vec_count,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int LANE_W  = idx_width(NUM_LANES);
  localparam int CHUNK_W = idx_width(CHUNK_WORDS);
  localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(NUM_LANES - 1);
  localparam logic [CHUNK_W-1:0] LAST_WORD = CHUNK_W'(CHUNK_WORDS - 1);

  state_e                state_q, state_d;
  logic [LANE_W-1:0]     lane_ptr_q, lane_ptr_d;
  logic [CHUNK_W-1:0]    chunk_q, chunk_d;
  logic [CNT_WIDTH-1:0]  vec_cnt_q, vec_cnt_d;
  logic                  frame_err_q, frame_err_d;
  logic [3:0]            wen_q;
  logic [DATA_WIDTH-1:0] wdata_q [4];

  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_head_last;
  logic                  w_head_valid;
  logic                  w_second_valid;
  logic [3:0]            w_rdy_vec;
  logic                  w_lane_rdy;
  logic                  w_write;
  logic                  w_accept;

  assign w_rdy_vec = {dispatcher3_ififo_rdy, dispatcher2_ififo_rdy,
                      dispatcher1_ififo_rdy, dispatcher0_ififo_rdy};

  // Only the lane under lane_ptr may release the head word: a stalled lane
  // holds up the whole stream, keeping writes strictly in order.
  always_comb begin
    w_lane_rdy = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (lane_ptr_q == LANE_W'(l)) w_lane_rdy = w_rdy_vec[l];
    end
  end

  assign w_write  = w_head_valid & w_lane_rdy;
  assign w_accept = s_axis_tvalid & s_axis_tready;

  axis_skid_buffer #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk            (clk),
    .reset          (reset),
    .s_data_i       ({s_axis_tlast, s_axis_tdata}),
    .s_valid_i      (s_axis_tvalid),
    .s_ready_o      (s_axis_tready),
    .m_data_o       ({w_head_last, w_head_data}),
    .m_valid_o      (w_head_valid),
    .m_ready_i      (w_lane_rdy),
    .second_valid_o (w_second_valid)
  );

  // Chunk / lane / vector bookkeeping, advanced once per write.
  always_comb begin
    lane_ptr_d  = lane_ptr_q;
    chunk_d     = chunk_q;
    vec_cnt_d   = vec_cnt_q;
    frame_err_d = frame_err_q;
    if (w_write) begin
      if (w_head_last) begin
        lane_ptr_d = '0;
        chunk_d    = '0;
        vec_cnt_d  = vec_cnt_q + CNT_WIDTH'(1);
        if (chunk_q != LAST_WORD) frame_err_d = 1'b1;
      end else if (chunk_q == LAST_WORD) begin
        chunk_d    = '0;
        lane_ptr_d = (lane_ptr_q == LAST_LANE) ? '0 : lane_ptr_q + LANE_W'(1);
      end else begin
        chunk_d = chunk_q + CHUNK_W'(1);
      end
    end
  end

  // A vector ends only when its tlast word leaves and nothing of the next
  // vector is buffered or arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_accept) state_d = ST_BUSY;
      ST_BUSY: begin
        if (w_write && w_head_last && !w_accept && !w_second_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lane_ptr_q  <= '0;
      chunk_q     <= '0;
      vec_cnt_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_ptr_q  <= lane_ptr_d;
      chunk_q     <= chunk_d;
      vec_cnt_q   <= vec_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  // wen is a single-cycle strobe; wdata of idle lanes keeps its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      wen_q <= 4'b0;
      for (int l = 0; l < 4; l++) wdata_q[l] <= '0;
    end else begin
      wen_q <= 4'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
        if (w_write && (lane_ptr_q == LANE_W'(l))) begin
          wen_q[l]   <= 1'b1;
          wdata_q[l] <= w_head_data;
        end
      end
    end
  end

  assign dispatcher0_ififo_wdata = wdata_q[0];
  assign dispatcher1_ififo_wdata = wdata_q[1];
  assign dispatcher2_ififo_wdata = wdata_q[2];
  assign dispatcher3_ififo_wdata = wdata_q[3];
  assign dispatcher0_ififo_wen   = wen_q[0];
  assign dispatcher1_ififo_wen   = wen_q[1];
  assign dispatcher2_ififo_wen   = wen_q[2];
  assign dispatcher3_ififo_wen   = wen_q[3];

  assign vec_count = vec_cnt_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == ST_BUSY) | w_head_valid | (|wen_q);

endmodule
`default_nettype wire

// File: tb/tb_mlp_dispatch_splitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mlp_dispatch_splitter
// Purpose  : Self-checking bench for mlp_dispatch_splitter. A reference
//            model computes, per vector, the lane of every word from its
//            index ((i / CHUNK) % LANES), the vector count and the framing
//            flag; observed writes are scored against it.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mlp_dispatch_splitter;

  localparam int DW      = 64;
  localparam int LANES   = 4;
  localparam int CHUNK   = 8;
  localparam int CW      = 16;
  localparam int WRAP_CW = 12;
  localparam int WRAP_N  = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic [DW-1:0] tdata = '0;
  logic          tvalid = 1'b0;
  logic          tlast = 1'b0;
  logic          tready;
  logic [DW-1:0] wd0, wd1, wd2, wd3;
  logic          wen0, wen1, wen2, wen3;
  logic [3:0]    rdy = 4'hF;
  logic [CW-1:0] vec_count;
  logic          frame_err, busy;

  // Second instance: one-word chunks, narrow counter, for the wrap check.
  logic [DW-1:0]      w_tdata = '0;
  logic               w_tvalid = 1'b0;
  logic               w_tready;
  logic [DW-1:0]      w_wd0, w_wd1, w_wd2, w_wd3;
  logic               w_wen0, w_wen1, w_wen2, w_wen3;
  logic [WRAP_CW-1:0] w_vec;
  logic               w_ferr, w_busy;

  mlp_dispatch_splitter #(.DATA_WIDTH(DW), .NUM_LANES(LANES), .CHUNK_WORDS(CHUNK), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(tready),
    .dispatcher0_ififo_wdata(wd0), .dispatcher0_ififo_wen(wen0), .dispatcher0_ififo_rdy(rdy[0]),
    .dispatcher1_ififo_wdata(wd1), .dispatcher1_ififo_wen(wen1), .dispatcher1_ififo_rdy(rdy[1]),
    .dispatcher2_ififo_wdata(wd2), .dispatcher2_ififo_wen(wen2), .dispatcher2_ififo_rdy(rdy[2]),
    .dispatcher3_ififo_wdata(wd3), .dispatcher3_ififo_wen(wen3), .dispatcher3_ififo_rdy(rdy[3]),
    .vec_count(vec_count), .frame_err(frame_err), .busy(busy)
  );

  mlp_dispatch_splitter #(.DATA_WIDTH(DW), .NUM_LANES(LANES), .CHUNK_WORDS(1), .CNT_WIDTH(WRAP_CW)) dut_wrap (
    .clk(clk), .reset(reset),
    .s_axis_tdata(w_tdata), .s_axis_tvalid(w_tvalid), .s_axis_tlast(1'b1), .s_axis_tready(w_tready),
    .dispatcher0_ififo_wdata(w_wd0), .dispatcher0_ififo_wen(w_wen0), .dispatcher0_ififo_rdy(1'b1),
    .dispatcher1_ififo_wdata(w_wd1), .dispatcher1_ififo_wen(w_wen1), .dispatcher1_ififo_rdy(1'b1),
    .dispatcher2_ififo_wdata(w_wd2), .dispatcher2_ififo_wen(w_wen2), .dispatcher2_ififo_rdy(1'b1),
    .dispatcher3_ififo_wdata(w_wd3), .dispatcher3_ififo_wen(w_wen3), .dispatcher3_ififo_rdy(1'b1),
    .vec_count(w_vec), .frame_err(w_ferr), .busy(w_busy)
  );

  typedef struct packed {
    logic [1:0]    lane;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] tx_data[$];
  logic          tx_last[$];
  int            exp_vec = 0;
  bit            exp_ferr = 1'b0;

  int n_vec = 0, n_err = 0;
  int cyc = 0, n_writes = 0, first_wr_edge = 0, last_wr_edge = 0, first_acc_edge = 0;
  int w_lane0_writes = 0, w_other_writes = 0;

  logic          rdy_rand = 1'b0;
  logic [3:0]    rdy_force = 4'hF;
  logic [DW-1:0] wd [4];
  assign wd[0] = wd0;
  assign wd[1] = wd1;
  assign wd[2] = wd2;
  assign wd[3] = wd3;

  always @(posedge clk) cyc++;

  // Lane ready: 75% high per lane in random mode, otherwise forced.
  always @(negedge clk) begin
    #1;
    if (rdy_rand) begin
      for (int l = 0; l < 4; l++) rdy[l] = ($urandom_range(0, 99) < 75);
    end else begin
      rdy = rdy_force;
    end
  end

  // Write scoreboard: every strobe must match the head of the model queue and
  // must have been launched while that lane's rdy was high.
  always @(posedge clk) begin
    logic [3:0] wens;
    wr_t        e;
    #1;
    wens = {wen3, wen2, wen1, wen0};
    if (!reset) begin
      for (int l = 0; l < 4; l++) begin
        if (wens[l]) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: lane %0d data %h, model expects no write", l, wd[l]);
          end else begin
            e = exp_q.pop_front();
            if (e.lane !== 2'(l) || e.data !== wd[l]) begin
              n_err++;
              $display("FAIL write_order: got lane %0d data %h, expected lane %0d data %h",
                       l, wd[l], e.lane, e.data);
            end
          end
          n_vec++;
          if (rdy[l] !== 1'b1) begin
            n_err++;
            $display("FAIL write_without_rdy: lane %0d rdy %b, required 1", l, rdy[l]);
          end
          n_writes++;
          if (n_writes == 1) first_wr_edge = cyc;
          last_wr_edge = cyc;
        end
      end
    end
    if (w_wen0) w_lane0_writes++;
    if (w_wen1 | w_wen2 | w_wen3) w_other_writes++;
  end

  // Reference model: word i of a vector goes to lane (i / CHUNK) % LANES.
  task automatic add_vector(input int len, input bit seq, input logic [DW-1:0] base);
    logic [DW-1:0] d;
    wr_t           e;
    for (int i = 0; i < len; i++) begin
      d = seq ? base + DW'(i) : {$urandom, $urandom};
      tx_data.push_back(d);
      tx_last.push_back(i == len - 1);
      e.lane = 2'((i / CHUNK) % LANES);
      e.data = d;
      exp_q.push_back(e);
    end
    exp_vec++;
    if ((len % CHUNK) != 0) exp_ferr = 1'b1;
  endtask

  task automatic send_stream(input int gap_pct, input int budget);
    int idx = 0;
    int guard = 0;
    int total;
    bit acc;
    total = tx_data.size();
    while (idx < total && guard < budget) begin
      @(negedge clk);
      guard++;
      if ($urandom_range(0, 99) < gap_pct) begin
        tvalid = 1'b0;
      end else begin
        tvalid = 1'b1;
        tdata  = tx_data[idx];
        tlast  = tx_last[idx];
      end
      acc = tvalid && tready;
      if (acc && idx == 0) first_acc_edge = cyc + 1;
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    n_vec++;
    if (idx != total) begin
      n_err++;
      $display("FAIL stream_accept: %0d of %0d words accepted within %0d cycles", idx, total, budget);
    end
    tx_data.delete();
    tx_last.delete();
  endtask

  task automatic wait_idle(input int budget);
    int g = 0;
    @(negedge clk);
    while (busy && g < budget) begin
      @(negedge clk);
      g++;
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL drain_timeout: busy %b after %0d cycles, required 0", busy, budget);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_vec  = 0;
    exp_ferr = 1'b0;
    n_writes = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec += 6;
    if (tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b, expected 0", tready); end
    if ({wen3, wen2, wen1, wen0} !== 4'b0) begin n_err++; $display("FAIL rst_wen: got %b, expected 0000", {wen3, wen2, wen1, wen0}); end
    if ({wd0, wd1, wd2, wd3} !== '0) begin n_err++; $display("FAIL rst_wdata: got %h, expected 0", {wd0, wd1, wd2, wd3}); end
    if (vec_count !== '0) begin n_err++; $display("FAIL rst_vec_count: got %0d, expected 0", vec_count); end
    if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_frame_err: got %b, expected 0", frame_err); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (tready !== 1'b1) begin n_err++; $display("FAIL rst_release_tready: got %b, expected 1", tready); end
  endtask

  task automatic test_single_vector();
    do_reset();
    rdy_rand  = 1'b0;
    rdy_force = 4'hF;
    add_vector(32, 1'b1, '0);
    send_stream(0, 200);
    wait_idle(200);
    n_vec += 6;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL single_missing: %0d writes outstanding, expected 0", exp_q.size()); end
    if (vec_count !== CW'(exp_vec)) begin n_err++; $display("FAIL single_vec_count: got %0d, expected %0d", vec_count, exp_vec); end
    if (frame_err !== exp_ferr) begin n_err++; $display("FAIL single_frame_err: got %b, expected %b", frame_err, exp_ferr); end
    if (first_wr_edge != first_acc_edge + 1) begin n_err++; $display("FAIL single_latency: first write edge %0d, expected %0d", first_wr_edge, first_acc_edge + 1); end
    if (last_wr_edge - first_wr_edge != 31) begin n_err++; $display("FAIL single_gaps: write span %0d edges, expected 31", last_wr_edge - first_wr_edge); end
    if (n_writes != 32) begin n_err++; $display("FAIL single_count: got %0d writes, expected 32", n_writes); end
  endtask

  task automatic test_backpressure();
    int g = 0;
    do_reset();
    rdy_force = 4'hF;
    add_vector(32, 1'b0, '0);
    fork
      send_stream(0, 400);
      begin
        while (n_writes < 8 && g < 200) begin
          @(negedge clk);
          g++;
        end
        rdy_force[1] = 1'b0;
        repeat (20) @(negedge clk);
        n_vec += 2;
        if (n_writes != 8) begin n_err++; $display("FAIL bp_stall_writes: got %0d writes during stall, expected 8", n_writes); end
        if (tready !== 1'b0) begin n_err++; $display("FAIL bp_tready: got %b during stall, expected 0", tready); end
        rdy_force[1] = 1'b1;
      end
    join
    wait_idle(200);
    n_vec += 2;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_missing: %0d writes outstanding, expected 0", exp_q.size()); end
    if (vec_count !== CW'(exp_vec)) begin n_err++; $display("FAIL bp_vec_count: got %0d, expected %0d", vec_count, exp_vec); end
  endtask

  task automatic test_short_vector();
    do_reset();
    add_vector(5, 1'b0, '0);
    send_stream(0, 100);
    wait_idle(100);
    n_vec += 3;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL short_missing: %0d writes outstanding, expected 0", exp_q.size()); end
    if (frame_err !== 1'b1) begin n_err++; $display("FAIL short_frame_err: got %b, expected 1", frame_err); end
    if (vec_count !== CW'(1)) begin n_err++; $display("FAIL short_vec_count: got %0d, expected 1", vec_count); end
    add_vector(3, 1'b0, '0);
    send_stream(0, 100);
    wait_idle(100);
    n_vec += 3;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL short_next_missing: %0d writes outstanding, expected 0", exp_q.size()); end
    if (frame_err !== exp_ferr) begin n_err++; $display("FAIL short_sticky: got %b, expected %b", frame_err, exp_ferr); end
    if (vec_count !== CW'(exp_vec)) begin n_err++; $display("FAIL short_next_vec_count: got %0d, expected %0d", vec_count, exp_vec); end
  endtask

  task automatic test_back_to_back();
    int g = 0;
    do_reset();
    add_vector(32, 1'b1, 64'h1000);
    add_vector(32, 1'b1, 64'h2000);
    fork
      send_stream(0, 300);
      begin
        while (n_writes < 64 && g < 300) begin
          @(negedge clk);
          g++;
        end
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_last_wen: got %b, expected 1", busy); end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_fall: got %b, expected 0", busy); end
      end
    join
    wait_idle(100);
    n_vec += 4;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_missing: %0d writes outstanding, expected 0", exp_q.size()); end
    if (last_wr_edge - first_wr_edge != 63) begin n_err++; $display("FAIL b2b_gaps: write span %0d edges, expected 63", last_wr_edge - first_wr_edge); end
    if (vec_count !== CW'(2)) begin n_err++; $display("FAIL b2b_vec_count: got %0d, expected 2", vec_count); end
    if (frame_err !== 1'b0) begin n_err++; $display("FAIL b2b_frame_err: got %b, expected 0", frame_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    add_vector(32, 1'b1, 64'h100);
    while (tx_data.size() > 13) begin
      void'(tx_data.pop_back());
      void'(tx_last.pop_back());
    end
    send_stream(0, 100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_vec  = 0;
    exp_ferr = 1'b0;
    n_writes = 0;
    repeat (10) @(negedge clk);
    n_vec += 5;
    if (n_writes != 0) begin n_err++; $display("FAIL midrst_writes: got %0d writes after reset, expected 0", n_writes); end
    if (vec_count !== '0) begin n_err++; $display("FAIL midrst_vec_count: got %0d, expected 0", vec_count); end
    if (frame_err !== 1'b0) begin n_err++; $display("FAIL midrst_frame_err: got %b, expected 0", frame_err); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
    if (tready !== 1'b1) begin n_err++; $display("FAIL midrst_tready: got %b, expected 1", tready); end
    add_vector(8, 1'b0, '0);
    send_stream(0, 100);
    wait_idle(100);
    n_vec += 3;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL midrst_next_missing: %0d writes outstanding, expected 0", exp_q.size()); end
    if (vec_count !== CW'(1)) begin n_err++; $display("FAIL midrst_next_vec_count: got %0d, expected 1", vec_count); end
    if (frame_err !== 1'b0) begin n_err++; $display("FAIL midrst_next_frame_err: got %b, expected 0", frame_err); end
  endtask

  task automatic test_random();
    do_reset();
    rdy_rand = 1'b1;
    for (int v = 0; v < 10; v++) add_vector($urandom_range(1, 40), 1'b0, '0);
    send_stream(25, 5000);
    wait_idle(2000);
    rdy_rand = 1'b0;
    n_vec += 3;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_missing: %0d writes outstanding, expected 0", exp_q.size()); end
    if (vec_count !== CW'(exp_vec)) begin n_err++; $display("FAIL rand_vec_count: got %0d, expected %0d", vec_count, exp_vec); end
    if (frame_err !== exp_ferr) begin n_err++; $display("FAIL rand_frame_err: got %b, expected %b", frame_err, exp_ferr); end
  endtask

  task automatic test_vec_wrap();
    int acc = 0;
    int guard = 0;
    do_reset();
    w_lane0_writes = 0;
    w_other_writes = 0;
    while (acc < WRAP_N && guard < WRAP_N + 100) begin
      @(negedge clk);
      guard++;
      w_tvalid = 1'b1;
      w_tdata  = {$urandom, $urandom};
      if (w_tready) acc++;
    end
    @(negedge clk);
    w_tvalid = 1'b0;
    guard = 0;
    while (w_busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_vec += 5;
    if (acc != WRAP_N) begin n_err++; $display("FAIL wrap_accepts: got %0d, expected %0d", acc, WRAP_N); end
    if (w_vec !== '0) begin n_err++; $display("FAIL wrap_vec_count: got %0d, expected 0", w_vec); end
    if (w_ferr !== 1'b0) begin n_err++; $display("FAIL wrap_frame_err: got %b, expected 0", w_ferr); end
    if (w_lane0_writes != WRAP_N) begin n_err++; $display("FAIL wrap_lane0_writes: got %0d, expected %0d", w_lane0_writes, WRAP_N); end
    if (w_other_writes != 0) begin n_err++; $display("FAIL wrap_other_lanes: got %0d writes, expected 0", w_other_writes); end
  endtask

  initial begin
    test_reset();
    test_single_vector();
    test_backpressure();
    test_short_vector();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_vec_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
